// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile renderer: colours, pipeline depth,
// clear-engine state encoding and default display geometry.
package vga_pkg;

    // 3-bit colours in {R,G,B} order
    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_GREEN   = 3'b010;
    localparam logic [2:0] COL_CYAN    = 3'b011;
    localparam logic [2:0] COL_RED     = 3'b100;
    localparam logic [2:0] COL_MAGENTA = 3'b101;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_WHITE   = 3'b111;

    // Cycles from an input sample to the matching RGB/sync outputs
    localparam int PIX_LATENCY = 3;

    // Default active area
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // Tile-map update engine states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/tile_ram.sv
// Single-port tile colour memory with a registered (read-first) output.
// Contents are not reset; callers only read locations they have written.
module tile_ram #(
    parameter int DEPTH = 120,
    parameter int AW    = 7
) (
    input  logic          Clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [2:0]    din,
    output logic [2:0]    dout
);

    logic [2:0] mem_q [DEPTH];

    // Write when enabled; the addressed word is always registered onto dout
    always_ff @(posedge Clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Pixel-colour stage behind the VGA timing controller. A three-stage pipeline
// turns (column,row,syncs) into registered RGB plus aligned syncs, reading a
// per-tile colour from tile_ram. Host writes and the clear engine share the
// single RAM port and only use cycles on which no pixel read is issued.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter  int H_ACTIVE   = DEF_H_ACTIVE,
    parameter  int V_ACTIVE   = DEF_V_ACTIVE,
    parameter  int TILE_SHIFT = 4,
    localparam int TILES_X    = H_ACTIVE >> TILE_SHIFT,
    localparam int TILES_Y    = V_ACTIVE >> TILE_SHIFT,
    localparam int N_TILES    = TILES_X * TILES_Y,
    localparam int AW         = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [9:0]    column_count,
    input  logic [9:0]    row_count,
    input  logic          VGA_HSYNC,
    input  logic          VGA_VSYNC,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    output logic          wr_ready,
    input  logic          clear_req,
    input  logic [2:0]    clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          VGA_RED,
    output logic          VGA_GREEN,
    output logic          VGA_BLUE,
    output logic          VGA_HSYNC_OUT,
    output logic          VGA_VSYNC_OUT
);

    localparam logic [10:0]   H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0]   V_LIM     = 11'(V_ACTIVE);
    localparam logic [31:0]   TX_U      = 32'(TILES_X);
    localparam logic [31:0]   N_U       = 32'(N_TILES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_TILES - 1);

    // S1: raw samples from the timing controller
    logic [9:0] col1_q;
    logic [9:0] row1_q;
    logic       hs1_q;
    logic       vs1_q;
    logic       v1_q;

    // S2: active flag and syncs travelling beside the RAM read
    logic       act2_q;
    logic       hs2_q;
    logic       vs2_q;

    // S3: output registers
    logic [2:0] rgb_q;
    logic [2:0] rgb_d;
    logic       hs3_q;
    logic       vs3_q;

    // Tile-map update engine
    fsm_state_e    state_q;
    logic [AW-1:0] clr_cnt_q;
    logic [2:0]    clr_color_q;
    logic          clear_busy_q;
    logic          clear_done_q;

    // Combinational control
    logic          act1_s;
    logic [31:0]   row_ext_s;
    logic [31:0]   col_ext_s;
    logic [AW-1:0] rd_addr_s;
    logic          wr_ready_s;
    logic          wr_accept_s;
    logic          wr_in_range_s;
    logic          clr_write_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_addr_s;
    logic [2:0]    ram_din_s;
    logic [2:0]    ram_dout_s;

    // Pixel-active decode with one cycle of lookahead: column_count reads 0
    // both at pixel 0 and during blanking, so S1 column 0 only counts as a
    // pixel when the following sample is column 1.
    always_comb begin
        act1_s = v1_q
              && ((col1_q != 10'd0) || (column_count == 10'd1))
              && ({1'b0, col1_q} < H_LIM)
              && ({1'b0, row1_q} < V_LIM)
              && vs1_q;
    end

    // Tile index of the S1 pixel: (row/tile)*TILES_X + (col/tile)
    always_comb begin
        row_ext_s = {22'd0, row1_q};
        col_ext_s = {22'd0, col1_q};
        rd_addr_s = AW'(((row_ext_s >> TILE_SHIFT) * TX_U) + (col_ext_s >> TILE_SHIFT));
    end

    // RAM port arbitration: pixel reads win, then the clear engine, then host writes
    always_comb begin
        wr_in_range_s = ({{(32-AW){1'b0}}, wr_addr} < N_U);
        if (Reset && (state_q == ST_IDLE) && !act1_s) begin
            wr_ready_s = 1'b1;
        end else begin
            wr_ready_s = 1'b0;
        end
        wr_accept_s = wr_valid & wr_ready_s;
        clr_write_s = Reset && (state_q == ST_CLEAR) && !act1_s;

        if (act1_s) begin
            ram_we_s   = 1'b0;
            ram_addr_s = rd_addr_s;
            ram_din_s  = COL_BLACK;
        end else if (clr_write_s) begin
            ram_we_s   = 1'b1;
            ram_addr_s = clr_cnt_q;
            ram_din_s  = clr_color_q;
        end else if (wr_accept_s && wr_in_range_s) begin
            ram_we_s   = 1'b1;
            ram_addr_s = wr_addr;
            ram_din_s  = wr_data;
        end else begin
            ram_we_s   = 1'b0;
            ram_addr_s = rd_addr_s;
            ram_din_s  = COL_BLACK;
        end
    end

    tile_ram #(
        .DEPTH (N_TILES),
        .AW    (AW)
    ) u_tile_ram (
        .Clock (Clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .din   (ram_din_s),
        .dout  (ram_dout_s)
    );

    // Blank the pixel unless it was an active read
    always_comb begin
        if (act2_q) begin
            rgb_d = ram_dout_s;
        end else begin
            rgb_d = COL_BLACK;
        end
    end

    // Three-stage pixel pipeline; reset drives idle syncs and clears valid flags
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            col1_q <= 10'd0;
            row1_q <= 10'd0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            v1_q   <= 1'b0;
            act2_q <= 1'b0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            rgb_q  <= COL_BLACK;
            hs3_q  <= 1'b1;
            vs3_q  <= 1'b1;
        end else begin
            col1_q <= column_count;
            row1_q <= row_count;
            hs1_q  <= VGA_HSYNC;
            vs1_q  <= VGA_VSYNC;
            v1_q   <= 1'b1;
            act2_q <= act1_s;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= rgb_d;
            hs3_q  <= hs2_q;
            vs3_q  <= vs2_q;
        end
    end

    // Clear engine: latch colour on request, then fill one tile per free cycle
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= {AW{1'b0}};
            clr_color_q  <= COL_BLACK;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q      <= ST_CLEAR;
                        clr_cnt_q    <= {AW{1'b0}};
                        clr_color_q  <= clear_color;
                        clear_busy_q <= 1'b1;
                    end else begin
                        clear_busy_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (!act1_s) begin
                        if (clr_cnt_q == LAST_ADDR) begin
                            state_q      <= ST_IDLE;
                            clear_busy_q <= 1'b0;
                            clear_done_q <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        clr_cnt_q <= clr_cnt_q;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready      = wr_ready_s;
    assign clear_busy    = clear_busy_q;
    assign clear_done    = clear_done_q;
    assign VGA_RED       = rgb_q[2];
    assign VGA_GREEN     = rgb_q[1];
    assign VGA_BLUE      = rgb_q[0];
    assign VGA_HSYNC_OUT = hs3_q;
    assign VGA_VSYNC_OUT = vs3_q;

endmodule
